// File: rtl/divider.sv
// Iterative restoring integer divider, signed or unsigned per operation.
// Latency: WIDTH/BITS_PER_CYCLE + 1 cycles after the start edge (1 cycle on divide-by-zero).
// Backpressure: none; valid_in while busy is ignored, and DONE holds results until the next start.
//
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   A, B, is_signed dividend, divisor and mode, sampled on the edge that sees valid_in
//   valid_in        start request (accepted in IDLE or DONE only)
//   quotient,
//   remainder       result registers; they change only when DONE is entered
//   valid_out, busy state == DONE, state == CALC
module divider #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             is_signed,
    input  logic             valid_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid_out,
    output logic             busy
);

    localparam int ITER  = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   dvd_q;      // dividend magnitude shifting out; quotient bits shift in
    logic [WIDTH-1:0]   dvs_q;      // divisor magnitude
    logic [WIDTH-1:0]   rem_q;      // partial remainder magnitude
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic [WIDTH-1:0]   quotient_q;
    logic [WIDTH-1:0]   remainder_q;

    // Operand magnitudes at the start edge.
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    always_comb begin
        a_neg = is_signed & A[WIDTH-1];
        b_neg = is_signed & B[WIDTH-1];
        a_mag = a_neg ? (~A + 1'b1) : A;
        b_mag = b_neg ? (~B + 1'b1) : B;
    end

    // BITS_PER_CYCLE restoring steps. The partial remainder is always below
    // the divisor, so the shifted value fits in WIDTH+1 bits and the top bit
    // of the trial difference is a clean borrow flag.
    logic [WIDTH-1:0]   dvd_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;

    always_comb begin
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        shifted = '0;
        trial   = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            shifted = {rem_d, dvd_d[WIDTH-1]};
            trial   = shifted - {1'b0, dvs_q};
            dvd_d   = {dvd_d[WIDTH-2:0], ~trial[WIDTH]};
            rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (valid_in) begin
                        if (B == '0) begin
                            state_q     <= DONE;
                            quotient_q  <= '1;
                            remainder_q <= A;
                        end else begin
                            state_q   <= CALC;
                            cnt_q     <= '0;
                            dvd_q     <= a_mag;
                            dvs_q     <= b_mag;
                            rem_q     <= '0;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                        end
                    end
                end
                CALC: begin
                    dvd_q <= dvd_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_q     <= DONE;
                        // MIN / -1 lands here too: magnitude 2^(WIDTH-1) with
                        // equal signs reads back as MIN, which is the wrapped answer.
                        quotient_q  <= neg_quo_q ? (~dvd_d + 1'b1) : dvd_d;
                        remainder_q <= neg_rem_q ? (~rem_d + 1'b1) : rem_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign valid_out = (state_q == DONE);
    assign busy      = (state_q == CALC);

endmodule

// File: tb/tb_divider.sv
// Bench for divider: arithmetic reference model plus directed literal cases and random traffic.
// Outputs are compared on every falling edge while out of reset.
// Inputs are driven 1 time unit after the rising edge.
module tb_divider;

    localparam int W    = 64;
    localparam int ITER = 16;
    localparam logic [W-1:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         is_signed = 1'b0;
    logic         valid_in = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         valid_out;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    divider #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .is_signed (is_signed),
        .valid_in  (valid_in),
        .quotient  (quotient),
        .remainder (remainder),
        .valid_out (valid_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference result {quotient, remainder} straight from the arithmetic rules.
    function automatic logic [2*W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
        logic [W-1:0] q;
        logic [W-1:0] r;
        longint sa;
        longint sb;
        if (b == '0) begin
            q = ONES;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == MIN && b == ONES) begin
            q = MIN;
            r = '0;
        end else begin
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end
        return {q, r};
    endfunction

    // Model: an accepted operation either completes at once (divisor zero) or
    // after ITER+1 edges counted from its start edge; starts are only taken
    // when no result is pending.
    logic [W-1:0] m_q;
    logic [W-1:0] m_r;
    logic [W-1:0] p_q;
    logic [W-1:0] p_r;
    logic         m_vout;
    int           m_left;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q    <= '0;
            m_r    <= '0;
            p_q    <= '0;
            p_r    <= '0;
            m_vout <= 1'b0;
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_vout <= 1'b1;
                m_q    <= p_q;
                m_r    <= p_r;
            end
        end else if (valid_in) begin
            if (B == '0) begin
                {m_q, m_r} <= golden(A, B, is_signed);
                m_vout     <= 1'b1;
            end else begin
                {p_q, p_r} <= golden(A, B, is_signed);
                m_vout     <= 1'b0;
                m_left     <= ITER;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("valid_out", {63'd0, valid_out}, {63'd0, m_vout});
            check("busy", {63'd0, busy}, {63'd0, (m_left > 0)});
            check("quotient", quotient, m_q);
            check("remainder", remainder, m_r);
        end
    end

    // Start one operation at the current time (just after an edge) and wait
    // for valid_out. toggle_at pulses valid_in with other operands mid-CALC;
    // rst_at asserts reset at that edge count and checks the cleared outputs.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input int elat, input int toggle_at, input int rst_at);
        int n;
        A = a;
        B = b;
        is_signed = s;
        valid_in = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) valid_in = 1'b0;
            if (toggle_at != 0 && n == toggle_at) begin
                valid_in = 1'b1;
                A = {$urandom, $urandom};
                B = 64'd5;
            end
            if (toggle_at != 0 && n == toggle_at + 1) valid_in = 1'b0;
            if (rst_at != 0 && n == rst_at) begin
                rst = 1'b0;
                #1;
                check({name, "_rst_vout"}, {63'd0, valid_out}, 64'd0);
                check({name, "_rst_busy"}, {63'd0, busy}, 64'd0);
                check({name, "_rst_q"}, quotient, 64'd0);
                check({name, "_rst_r"}, remainder, 64'd0);
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b1;
                return;
            end
            if (valid_out) break;
        end
        valid_in = 1'b0;
        check({name, "_latency"}, 64'(n), 64'(elat));
        check({name, "_q"}, quotient, eq);
        check({name, "_r"}, remainder, er);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_vout", {63'd0, valid_out}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_q", quotient, 64'd0);
        check("reset_r", remainder, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_op("u100_7", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 17, 0, 0);
        run_op("s-100_7", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1,
               64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 17, 0, 0);
        run_op("s100_-7", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1,
               64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 17, 0, 0);
        run_op("s-100_-7", 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1,
               64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 17, 0, 0);
        run_op("u_bgta", 64'd5, 64'd9, 1'b0, 64'd0, 64'd5, 17, 0, 0);
        run_op("div0_u", 64'h1234, 64'd0, 1'b0, ONES, 64'h1234, 1, 0, 0);
        run_op("div0_s", 64'h1234, 64'd0, 1'b1, ONES, 64'h1234, 1, 0, 0);
        run_op("s_ovf", MIN, ONES, 1'b1, MIN, 64'd0, 17, 0, 0);
        run_op("rst_mid", 64'd100, 64'd7, 1'b0, 64'd0, 64'd0, 17, 0, 5);
        run_op("ignore", 64'd1000, 64'd9, 1'b0, 64'd111, 64'd1, 17, 5, 0);
        run_op("b2b_1", ONES, 64'h10, 1'b0, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 17, 0, 0);
        run_op("b2b_2", 64'd5, 64'd10, 1'b0, 64'd0, 64'd5, 17, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            valid_in  = ($urandom_range(0, 3) == 0);
            is_signed = $urandom_range(0, 1) == 1;
            A = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: B = '0;
                1: B = 64'($urandom_range(1, 15));
                2: begin
                    A = MIN;
                    B = ONES;
                    is_signed = 1'b1;
                end
                3: B = {32'd0, $urandom};
                4: B = ONES - 64'($urandom_range(0, 20));
                default: B = {$urandom, $urandom};
            endcase
        end
        valid_in = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
